// File: rtl/axi_coeff_slave.sv
// axi_coeff_slave: AXI4-Lite slave that drives the coefficient register-write port
// and keeps a 16-bit readback shadow of every coefficient word.
`default_nettype none

module axi_coeff_slave #(
  parameter int NUM_COEFF = 25,
  parameter int ADDR_W    = 8
) (
  input  logic              microblaze_clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb
);

  localparam int               IDX_W     = ADDR_W - 2;
  localparam int               SH_W      = $clog2(NUM_COEFF);
  localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(NUM_COEFF);
  localparam logic [1:0]       RESP_OKAY = 2'b00;
  localparam logic [1:0]       RESP_SLV  = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  wstate_t           wstate_q;
  rstate_t           rstate_q;
  logic              aw_full_q, w_full_q;
  logic [IDX_W-1:0]  awidx_q;
  logic [15:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]        bresp_q, rresp_q;
  logic [31:0]       rdata_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [3:0]        wr_strb_q;
  logic [15:0]       shadow_q [NUM_COEFF];

  logic              aw_hs, w_hs, ar_hs;
  logic              aw_ok, ar_ok;
  logic [IDX_W-1:0]  aridx;
  logic [15:0]       cur_word, merge_d, rd_word;
  logic              unused_ok;

  assign aw_hs = s_awvalid && awready_q;
  assign w_hs  = s_wvalid && wready_q;
  assign ar_hs = s_arvalid && arready_q;
  assign aridx = s_araddr[ADDR_W-1:2];
  assign aw_ok = awidx_q < IDX_LIMIT;
  assign ar_ok = aridx < IDX_LIMIT;

  // Shadow lookups are guarded by the range check so the truncated index never escapes.
  assign cur_word = aw_ok ? shadow_q[awidx_q[SH_W-1:0]] : 16'h0000;
  assign rd_word  = ar_ok ? shadow_q[aridx[SH_W-1:0]] : 16'h0000;
  assign merge_d  = {wstrb_q[1] ? wdata_q[15:8] : cur_word[15:8],
                     wstrb_q[0] ? wdata_q[7:0]  : cur_word[7:0]};

  assign unused_ok = &{1'b0, s_wdata[31:16], s_awaddr[1:0], s_araddr[1:0]};

  always_ff @(posedge microblaze_clk) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      for (int i = 0; i < NUM_COEFF; i++) shadow_q[i] <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            awidx_q   <= s_awaddr[ADDR_W-1:2];
            aw_full_q <= 1'b1;
            awready_q <= 1'b0;
          end else begin
            awready_q <= !aw_full_q;
          end
          if (w_hs) begin
            wdata_q  <= s_wdata[15:0];
            wstrb_q  <= s_wstrb;
            w_full_q <= 1'b1;
            wready_q <= 1'b0;
          end else begin
            wready_q <= !w_full_q;
          end
          if ((aw_full_q || aw_hs) && (w_full_q || w_hs)) wstate_q <= W_EXEC;
        end
        W_EXEC: begin
          if (aw_ok) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {awidx_q, 2'b00};
            wr_data_q <= {{16{merge_d[15]}}, merge_d};
            wr_strb_q <= wstrb_q;
            shadow_q[awidx_q[SH_W-1:0]] <= merge_d;
          end
          bresp_q  <= aw_ok ? RESP_OKAY : RESP_SLV;
          bvalid_q <= 1'b1;
          wstate_q <= W_RESP;
        end
        W_RESP: begin
          if (s_bready) begin
            bvalid_q  <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read path samples the shadow before any same-edge write lands, so it sees the old value.
  always_ff @(posedge microblaze_clk) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= {{16{rd_word[15]}}, rd_word};
            rresp_q   <= ar_ok ? RESP_OKAY : RESP_SLV;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_strb   = wr_strb_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_coeff_slave.sv
// tb_axi_coeff_slave: table-driven bus transactions plus reset-in-flight sequence.
`default_nettype none

module tb_axi_coeff_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [7:0]  wr_addr;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_coeff_slave #(.NUM_COEFF(25), .ADDR_W(8)) dut (
    .microblaze_clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_strb(wr_strb)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    int          hold;
    int          exp_pulse;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input vec_t v, input int n);
    int cyc = 0, pulses = 0, holdbad = 0;
    bit awh, wh;
    s_awaddr = v.addr; s_wdata = v.data; s_wstrb = v.strb;
    s_wvalid = 1'b1; s_awvalid = (v.lead == 0); s_bready = 1'b0;
    while (!s_bvalid && cyc < 50) begin
      awh = s_awvalid && s_awready;
      wh  = s_wvalid && s_wready;
      tick();
      cyc++;
      if (awh) s_awvalid = 1'b0;
      if (wh)  s_wvalid  = 1'b0;
      if (cyc == v.lead) s_awvalid = 1'b1;
      if (wr_en) pulses++;
    end
    chk($sformatf("v%0d_b_timeout", n), {31'd0, s_bvalid}, 32'd1);
    chk($sformatf("v%0d_bresp", n), {30'd0, s_bresp}, {30'd0, v.exp_resp});
    for (int i = 0; i < v.hold; i++) begin
      tick();
      if (wr_en) pulses++;
      if (!s_bvalid || s_awready || s_wready) holdbad++;
    end
    if (v.hold > 0) chk($sformatf("v%0d_bhold", n), holdbad, 0);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    if (wr_en) pulses++;
    chk($sformatf("v%0d_bvalid_drop", n), {31'd0, s_bvalid}, 32'd0);
    chk($sformatf("v%0d_wr_en_pulses", n), pulses, v.exp_pulse);
    chk($sformatf("v%0d_wr_addr", n), {24'd0, wr_addr}, {24'd0, v.exp_addr});
    chk($sformatf("v%0d_wr_data", n), wr_data, v.exp_data);
  endtask

  task automatic do_read(input vec_t v, input int n);
    int cyc = 0, holdbad = 0;
    bit arh;
    logic [31:0] first;
    s_araddr = v.addr; s_arvalid = 1'b1; s_rready = 1'b0;
    while (!s_rvalid && cyc < 50) begin
      arh = s_arvalid && s_arready;
      tick();
      cyc++;
      if (arh) s_arvalid = 1'b0;
    end
    chk($sformatf("v%0d_r_timeout", n), {31'd0, s_rvalid}, 32'd1);
    chk($sformatf("v%0d_rdata", n), s_rdata, v.exp_data);
    chk($sformatf("v%0d_rresp", n), {30'd0, s_rresp}, {30'd0, v.exp_resp});
    first = s_rdata;
    for (int i = 0; i < v.hold; i++) begin
      tick();
      if (!s_rvalid || s_arready || s_rdata !== first) holdbad++;
    end
    if (v.hold > 0) chk($sformatf("v%0d_rhold", n), holdbad, 0);
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
    chk($sformatf("v%0d_rvalid_drop", n), {31'd0, s_rvalid}, 32'd0);
  endtask

  initial begin
    int cyc;
    bit awh, wh, arh;
    vec_t rv;

    //          wr addr   data          strb  lead hold pulse exp_addr exp_data      resp
    tbl[0]  = '{1, 8'h08, 32'h0000_1234, 4'hF, 0, 0, 1, 8'h08, 32'h0000_1234, 2'b00};
    tbl[1]  = '{0, 8'h08, 32'h0,         4'h0, 0, 0, 0, 8'h00, 32'h0000_1234, 2'b00};
    tbl[2]  = '{1, 8'h60, 32'hFFFF_8001, 4'hF, 3, 5, 1, 8'h60, 32'hFFFF_8001, 2'b00};
    tbl[3]  = '{0, 8'h60, 32'h0,         4'h0, 0, 4, 0, 8'h00, 32'hFFFF_8001, 2'b00};
    tbl[4]  = '{1, 8'h04, 32'h0000_0011, 4'h1, 0, 0, 1, 8'h04, 32'h0000_0011, 2'b00};
    tbl[5]  = '{1, 8'h04, 32'h0000_AB00, 4'h2, 0, 0, 1, 8'h04, 32'hFFFF_AB11, 2'b00};
    tbl[6]  = '{0, 8'h05, 32'h0,         4'h0, 0, 0, 0, 8'h00, 32'hFFFF_AB11, 2'b00};
    tbl[7]  = '{1, 8'h64, 32'h1234_5678, 4'hF, 0, 0, 0, 8'h04, 32'hFFFF_AB11, 2'b10};
    tbl[8]  = '{0, 8'hFC, 32'h0,         4'h0, 0, 0, 0, 8'h00, 32'h0000_0000, 2'b10};
    tbl[9]  = '{0, 8'h60, 32'h0,         4'h0, 0, 0, 0, 8'h00, 32'hFFFF_8001, 2'b00};
    tbl[10] = '{1, 8'h0B, 32'hDEAD_5A5A, 4'hC, 0, 0, 1, 8'h08, 32'h0000_1234, 2'b00};
    tbl[11] = '{1, 8'h10, 32'h0000_7FFF, 4'h3, 2, 0, 1, 8'h10, 32'h0000_7FFF, 2'b00};
    tbl[12] = '{0, 8'h10, 32'h0,         4'h0, 0, 0, 0, 8'h00, 32'h0000_7FFF, 2'b00};

    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
    s_araddr = '0; s_arvalid = 0; s_rready = 0;
    repeat (3) tick();
    chk("reset_outputs",
        {s_awready, s_wready, s_bvalid, s_arready, s_rvalid, wr_en, s_bresp, s_rresp},
        32'd0);
    chk("reset_wr_bus", {wr_addr, wr_strb, 20'd0} | wr_data, 32'd0);
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd7);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) do_write(tbl[i], i);
      else           do_read(tbl[i], i);
      tick();
    end
    chk("wr_strb_held", {28'd0, wr_strb}, 32'h3);

    // Park one write in W_RESP and one read in R_DATA, then reset.
    s_awaddr = 8'h08; s_wdata = 32'h0000_5555; s_wstrb = 4'hF;
    s_araddr = 8'h10;
    s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 0; s_rready = 0;
    cyc = 0;
    while (!(s_bvalid && s_rvalid) && cyc < 30) begin
      awh = s_awvalid && s_awready;
      wh  = s_wvalid && s_wready;
      arh = s_arvalid && s_arready;
      tick();
      cyc++;
      if (awh) s_awvalid = 0;
      if (wh)  s_wvalid  = 0;
      if (arh) s_arvalid = 0;
    end
    chk("inflight_reached", {30'd0, s_bvalid, s_rvalid}, 32'd3);
    rst = 1'b1;
    tick();
    chk("rst_inflight_valids", {28'd0, s_bvalid, s_rvalid, wr_en, s_awready}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_no_late_resp", {30'd0, s_bvalid, s_rvalid}, 32'd0);

    for (int k = 0; k < 25; k++) begin
      rv = '{0, 8'(k * 4), 32'h0, 4'h0, 0, 0, 0, 8'h00, 32'h0, 2'b00};
      do_read(rv, 100 + k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
